// File: rtl/serial_adder.sv
// serial_adder: bit-serial {cout,sum} = a + b + cin, LSB first, one full-adder cell.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and forced carry-in).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, done_q, done_d;
  logic accept, run, last, s, co, sub_w;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif
  assign run    = state_q == RUN;
  assign accept = start && state_q == IDLE;
  assign last   = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = run ? (last ? IDLE : RUN) : (accept ? RUN : IDLE);
  end
  always_comb begin
    busy = run;
    done = done_q;
    sum  = sum_q;
    cout = cout_q;
  end
  // The single full-adder cell; result bits enter at the MSB so bit 0 ends up in place.
  always_comb begin
    s      = a_q[0] ^ b_q[0] ^ c_q;
    co     = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    a_d    = accept ? a : run ? a_q >> 1 : a_q;
    b_d    = accept ? (sub_w ? ~b : b) : run ? b_q >> 1 : b_q;
    c_d    = accept ? (sub_w | cin) : run ? co : c_q;
    cnt_d  = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    res_d  = run ? ((res_q >> 1) | (WIDTH'(s) << (WIDTH - 1))) : res_q;
    sum_d  = (run && last) ? res_d : sum_q;
    cout_d = (run && last) ? co : cout_q;
    done_d = run && last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      cout_q <= cout_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8.
module tb_serial_adder;
  logic clk = 0, rst = 1, start = 0, cin = 0, sub = 0;
  logic [7:0] a = 0, b = 0, sum;
  logic cout, busy, done;
  int checks = 0, failures = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .sum(sum), .cout(cout), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, scramble the operands after acceptance, wait for done.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts,
                       output int lat, output int bcnt, output logic held);
    logic [8:0] prev;
    prev = {cout, sum};
    a = ta; b = tb_; cin = tc; sub = ts; start = 1;
    tick();
    start = 0; a = ~ta; b = ~tb_; cin = ~tc; sub = ~ts;
    lat = 0; bcnt = 0; held = 1;
    while (!done && lat < 40) begin
      bcnt += int'(busy);
      if ({cout, sum} !== prev) held = 0;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1; tick(); tick();
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    rst = 0; tick();
  endtask

  task automatic test_basic;
    int lat, bcnt; logic held;
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bcnt, held);
    checks += 6;
    if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    if (bcnt !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bcnt); end
    if (held !== 1'b1) begin failures++; $display("FAIL basic_sum_held got=%b exp=1", held); end
    if (sum !== 8'h96) begin failures++; $display("FAIL basic_sum got=%h exp=96", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", cout); end
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_carry;
    int lat, bcnt; logic held;
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt, held);
    checks += 3;
    if (lat !== 8) begin failures++; $display("FAIL carry1_latency got=%0d exp=8", lat); end
    if (sum !== 8'h00) begin failures++; $display("FAIL carry1_sum got=%h exp=00", sum); end
    if (cout !== 1'b1) begin failures++; $display("FAIL carry1_cout got=%b exp=1", cout); end
    tick();
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bcnt, held);
    checks += 2;
    if (sum !== 8'hFF) begin failures++; $display("FAIL carry2_sum got=%h exp=FF", sum); end
    if (cout !== 1'b1) begin failures++; $display("FAIL carry2_cout got=%b exp=1", cout); end
    tick();
  endtask

  task automatic test_back_to_back;
    int n;
    a = 8'h5A; b = 8'h3C; cin = 0; start = 1;
    tick();
    a = 8'h01; b = 8'h02;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    checks += 3;
    if (n !== 8) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=8", n); end
    if (sum !== 8'h96) begin failures++; $display("FAIL b2b_first_sum got=%h exp=96", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL b2b_first_cout got=%b exp=0", cout); end
    tick();
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_fall got=%b exp=0", done); end
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_rise got=%b exp=1", busy); end
    n = 1;
    while (!done && n < 40) begin tick(); n++; end
    checks += 3;
    if (n !== 9) begin failures++; $display("FAIL b2b_period got=%0d exp=9", n); end
    if (sum !== 8'h03) begin failures++; $display("FAIL b2b_second_sum got=%h exp=03", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL b2b_second_cout got=%b exp=0", cout); end
    start = 0;
    tick();
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL b2b_end_done got=%b exp=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_start_ignored;
    int n;
    a = 8'h80; b = 8'h80; cin = 0; start = 1;
    tick();
    start = 0; tick(); tick();
    start = 1; a = 8'h0F; b = 8'h0F; cin = 1;
    tick();
    start = 0;
    n = 3;
    while (!done && n < 40) begin tick(); n++; end
    checks += 3;
    if (n !== 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", n); end
    if (sum !== 8'h00) begin failures++; $display("FAIL ignore_sum got=%h exp=00", sum); end
    if (cout !== 1'b1) begin failures++; $display("FAIL ignore_cout got=%b exp=1", cout); end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got=%b exp=0", busy); end
  endtask

  task automatic test_abort;
    int lat, bcnt; logic held, seen;
    a = 8'h33; b = 8'h44; cin = 0; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    if (sum !== 8'h00) begin failures++; $display("FAIL abort_sum got=%h exp=00", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL abort_cout got=%b exp=0", cout); end
    seen = 0;
    repeat (12) begin if (done) seen = 1; tick(); end
    checks += 2;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    if (sum !== 8'h00) begin failures++; $display("FAIL abort_sum_stays got=%h exp=00", sum); end
    do_op(8'h12, 8'h34, 1'b1, 1'b0, lat, bcnt, held);
    checks += 3;
    if (lat !== 8) begin failures++; $display("FAIL abort_next_latency got=%0d exp=8", lat); end
    if (sum !== 8'h47) begin failures++; $display("FAIL abort_next_sum got=%h exp=47", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL abort_next_cout got=%b exp=0", cout); end
    tick();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat, bcnt; logic held;
    do_op(8'h10, 8'h01, 1'b0, 1'b1, lat, bcnt, held);
    checks += 2;
    if (sum !== 8'h0F) begin failures++; $display("FAIL sub1_sum got=%h exp=0F", sum); end
    if (cout !== 1'b1) begin failures++; $display("FAIL sub1_cout got=%b exp=1", cout); end
    tick();
    do_op(8'h00, 8'h01, 1'b1, 1'b1, lat, bcnt, held);
    checks += 2;
    if (sum !== 8'hFF) begin failures++; $display("FAIL sub2_sum got=%h exp=FF", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL sub2_cout got=%b exp=0", cout); end
    tick();
    do_op(8'h10, 8'h01, 1'b1, 1'b0, lat, bcnt, held);
    checks += 2;
    if (sum !== 8'h12) begin failures++; $display("FAIL sub0_sum got=%h exp=12", sum); end
    if (cout !== 1'b0) begin failures++; $display("FAIL sub0_cout got=%b exp=0", cout); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_start_ignored();
    test_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  operand A; sampled only at an accepting edge.
REQ-006 Port: b  input  WIDTH  operand B; sampled only at an accepting edge.
REQ-007 Port: cin  input  1  carry-in; sampled only at an accepting edge.
REQ-008 Port: sum  output  WIDTH  registered result.
REQ-009 Port: cout  output  1  registered carry-out of the MSB.
REQ-010 Port: busy  output  1  registered; high while the operation is in progress.
REQ-011 Port: done  output  1  registered; one-cycle completion pulse.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin, one bit per clock, LSB first, using one one-bit full-adder cell.
REQ-013 The FSM SHALL have exactly two states: IDLE (busy=0) and RUN (busy=1).
REQ-014 Accepting edge: a rising edge with start=1, busy=0, and rst=0.
REQ-015 On an accepting edge, the block SHALL:
  - load a and b into internal shift registers;
  - load cin into the carry flop;
  - clear the bit counter;
  - enter RUN.
REQ-016 Each RUN edge SHALL:
  - add operand bit 0 of each shift register with the carry flop;
  - shift the resulting sum bit into the MSB end of an internal result register;
  - store the cell carry in the carry flop;
  - shift the operands right;
  - increment the counter.
REQ-017 The edge that processes bit WIDTH-1 SHALL:
  - copy the completed result to sum and the final carry to cout;
  - set done=1;
  - return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle after the WIDTH-th edge following the accepting edge; for WIDTH=8, done is high after edge 8.
REQ-019 done SHALL be high for exactly one cycle per completed operation.
REQ-020 busy SHALL fall in the same cycle that done rises.
REQ-021 sum and cout SHALL change only at the completion edge.
REQ-022 sum and cout SHALL hold their previous values during RUN and in IDLE.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-024 start=1 in the done cycle SHALL be accepted (back-to-back operation); done then falls and busy rises on that edge.
REQ-025 Changes on a, b, or cin after the accepting edge SHALL NOT affect the result.
REQ-026 For WIDTH=1, the operation SHALL complete after one RUN edge.
REQ-027 The counter SHALL be sized ceil(log2(WIDTH))+1 bits and SHALL NOT wrap during an operation.

Reset
REQ-028 rst=1 at a rising edge SHALL force:
  - state to IDLE;
  - busy=0, done=0;
  - sum=0, cout=0;
  - counter, carry, and shift registers to 0.
REQ-029 rst=1 SHALL take priority over start.
REQ-030 rst=1 during RUN SHALL abort the operation; no done pulse is produced and sum stays 0.

Configuration
REQ-031 Macro SERIAL_ADDER_SUB_EN defined: the block SHALL add the port sub (input, 1 bit), sampled at the accepting edge.
REQ-032 With SERIAL_ADDER_SUB_EN and sub=1, the block SHALL:
  - load ~b;
  - force the carry flop to 1, ignoring cin;
  - give sum = (a - b) mod 2^WIDTH;
  - give cout=1 when no borrow occurs (a >= b unsigned).
REQ-033 With SERIAL_ADDER_SUB_EN and sub=0, behaviour SHALL be identical to addition.
REQ-034 SERIAL_ADDER_SUB_EN undefined: the sub port SHALL be absent and the block SHALL perform addition only.

Verification (WIDTH=8)
REQ-035 a=0x5A, b=0x3C, cin=0, start pulse -> done after edge 8; sum=0x96, cout=0; busy high for 8 cycles.
REQ-036 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-037 start held high continuously with new operands 0x01+0x02 loaded mid-run -> first result is unaffected.
REQ-038 start held high continuously -> the second operation is accepted in the done cycle, and done pulses every 9 cycles.
REQ-039 rst=1 asserted at RUN edge 4 -> busy=0, no done, sum=0x00, cout=0; a following start completes normally.
REQ-040 SERIAL_ADDER_SUB_EN defined, sub=1: a=0x10, b=0x01 -> sum=0x0F, cout=1.
REQ-041 SERIAL_ADDER_SUB_EN defined, sub=1: a=0x00, b=0x01 -> sum=0xFF, cout=0.
